pipe_slot_ctrl: RTL
===================

# pipe_slot_ctrl

Parametrised pipeline occupancy controller for the MIPS CPU. It tracks DEPTH in-flight instruction slots, each with a valid bit and a tag, and replaces the single-instruction stage counter of the multi-cycle control FSM. It applies prioritised stall (bubble) and flush requests per stage, gates new-instruction issue with a valid/ready handshake, and reports retirement from the last stage. It sits between the fetch unit (issue side) and the per-stage decode/control logic, which reads `stage_valid` and `stage_tag`.

## Interface
- `DEPTH`, 5: number of pipeline stages, 2..8. Stage 0 is youngest; stage DEPTH-1 is oldest.
- `TAG_W`, 32: tag width per slot (normally the instruction word).
- `REFILL_GAP`, 1: cycles that issue stays blocked after a flush, 0..7.
- `SW`, derived, $clog2(DEPTH+1): stage-index width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `issue_valid`  in  1  fetch offers an instruction.
- `issue_tag`  in  TAG_W  tag of the offered instruction.
- `issue_ready`  out  1  slot 0 accepts this cycle; transfer happens when valid&&ready.
- `stall`  in  1  bubble request.
- `stall_stage`  in  SW  stages 0..stall_stage hold; values ≥DEPTH are clamped to DEPTH-1.
- `flush`  in  1  flush request.
- `flush_stage`  in  SW  kill stages with index < flush_stage; 0 is a no-op; ≥DEPTH kills all.
- `stage_valid`  out  DEPTH  per-stage occupancy, registered.
- `stage_tag`  out  DEPTH*TAG_W  per-stage tags, stage i at [i*TAG_W +: TAG_W], registered.
- `retire_valid`  out  1  the oldest stage leaves the pipe this cycle.
- `retire_tag`  out  TAG_W  equals the stage DEPTH-1 tag.
- `busy`  out  1  OR of `stage_valid`.
- `perf_retired`  out  32  count of retirements.
- `perf_bubbles`  out  32  count of bubbles inserted.

## Operation
- Reset: all valid bits 0, all tags 0, gap counter 0, perf counters 0. `issue_ready` is 1 and `retire_valid`/`busy` are 0 once reset is released.
- Priority: flush > stall > normal advance. When `flush` is high, `stall` is ignored for that cycle.
- Normal advance: stage i+1 takes stage i (valid and tag). Stage 0 takes `issue_tag` with valid=1 if a transfer occurs, otherwise valid=0.
- Stall (s = clamped `stall_stage`):
  - Stages 0..s hold.
  - Stage s+1 loads valid=0 (bubble); its tag is don't-care and held.
  - Stages > s+1 advance normally.
  - If s = DEPTH-1, the whole pipe holds and nothing retires.
  - A bubble is counted only when s < DEPTH-1 and stage s was valid.
- Flush (f = `flush_stage`):
  - Stages with index < f load valid=0.
  - Stages ≥ f advance normally; oldest-stage retirement still occurs if f ≤ DEPTH-1.
  - No issue occurs in the flush cycle.
  - If f>0, the gap counter loads REFILL_GAP.
- Gap counter decrements each cycle while nonzero, then saturates at 0.
- `issue_ready` = ~`flush` & ~`stall` & (gap==0). It is combinational; `issue_valid` must not depend on it.
- `retire_valid` = `stage_valid`[DEPTH-1] & ~(`stall` & s==DEPTH-1 & ~`flush`) & ~(`flush` & f==DEPTH or more). It is combinational from registered state and inputs.
- Each tag register loads only when its stage advances with valid data, which limits toggling.

## Timing
- Issue-to-stage-0: a transfer in cycle n shows `stage_valid`[0]=1 in cycle n+1.
- Minimum residency: an unstalled instruction is in stage DEPTH-1 at cycle n+DEPTH and retires in that same cycle (`retire_valid` high).
- Flush at cycle n with REFILL_GAP=g: `issue_ready` is low in cycles n..n+g and high at n+g+1 if not stalled. With g=0, issue resumes at n+1.
- A flush and a stall arriving together behave exactly as the flush alone.
- Asserting reset mid-operation clears all state asynchronously. Partially advanced slots are lost and no retirement is reported.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `perf_retired` increments on each `retire_valid` cycle.
  - `perf_bubbles` increments on each counted bubble.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- `PIPE_PERF_CNT_EN` undefined: no counter flops are built, and both ports are tied to 0.

## Test plan
- DEPTH=5, reset, then issue tags 0x1..0x3 back-to-back -> 0x1 retires at cycle 5 after its issue and 0x2/0x3 on the following cycles; `busy` falls one cycle after 0x3 retires.
- Fill all 5 stages, then `stall` with stall_stage=1 for 2 cycles -> stages 0–1 hold, stage 2 shows valid=0 for 2 cycles, `issue_ready`=0, `perf_bubbles`=2.
- Full pipe, `flush` with flush_stage=3, REFILL_GAP=2 -> stages 0–2 invalid, stage 4 retires that cycle, `issue_ready` low for 3 cycles and high on the 4th.
- `flush` with flush_stage=5 and `stall` together -> all stages invalid, `retire_valid`=0, and the stall has no effect.
- stall_stage=7 with DEPTH=5 -> clamped to 4: the entire pipe holds and `retire_valid`=0 while the stall is asserted.
- Assert `rst_n` low mid-stream with 3 valid slots -> all `stage_valid`=0 immediately; with `PIPE_PERF_CNT_EN` defined, both counters read 0.

Source files
------------

// File: rtl/pipe_slot_ctrl.sv
// pipe_slot_ctrl: in-flight instruction slot tracker for the MIPS pipeline.
// Each of DEPTH stages carries a valid bit and a tag. Per cycle the pipe does
// one of three things, in this priority order: flush, stall (bubble), or
// normal advance. New instructions enter stage 0 through a valid/ready
// handshake, and instructions leave from the oldest stage.
// Optional build macro: PIPE_PERF_CNT_EN adds retire/bubble performance
// counters. Without it, both counter ports are tied to zero.
module pipe_slot_ctrl #(
    parameter int DEPTH      = 5,
    parameter int TAG_W      = 32,
    parameter int REFILL_GAP = 1,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic [TAG_W-1:0]       issue_tag,
    output logic                   issue_ready,
    input  logic                   stall,
    input  logic [SW-1:0]          stall_stage,
    input  logic                   flush,
    input  logic [SW-1:0]          flush_stage,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*TAG_W-1:0] stage_tag,
    output logic                   retire_valid,
    output logic [TAG_W-1:0]       retire_tag,
    output logic                   busy,
    output logic [31:0]            perf_retired,
    output logic [31:0]            perf_bubbles
);

    localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [TAG_W-1:0] tag_reg [DEPTH];
    logic [TAG_W-1:0] tag_in  [DEPTH];
    logic [DEPTH-1:0] tag_load;
    logic [2:0]       gap_reg;
    logic [2:0]       gap_next;

    logic [SW-1:0]    stall_sel;
    logic             stall_eff;
    logic             flush_all;
    logic             transfer;

    // Out-of-range stall indices freeze the whole pipe.
    assign stall_sel = (stall_stage > LAST) ? LAST : stall_stage;
    // A flush always wins, so a simultaneous stall is ignored.
    assign stall_eff = stall & ~flush;
    assign flush_all = flush & (flush_stage > LAST);

    // Issue is blocked while flushing, stalling or refilling after a flush.
    assign issue_ready = ~flush & ~stall & (gap_reg == 3'd0);
    assign transfer    = issue_valid & issue_ready;

    // The oldest slot leaves unless the whole pipe is frozen or killed.
    assign retire_valid = valid_reg[DEPTH-1]
                        & ~(stall_eff & (stall_sel == LAST))
                        & ~flush_all;
    assign retire_tag   = tag_reg[DEPTH-1];

    assign stage_valid = valid_reg;
    assign busy        = |valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            localparam logic [SW-1:0] IDX = SW'(gi);
            logic             up_valid;
            logic             kill;
            logic             hold;
            logic             bubble;

            if (gi == 0) begin : g_head
                // Stage 0 is fed by the fetch handshake.
                assign up_valid   = transfer;
                assign tag_in[gi] = issue_tag;
            end else begin : g_body
                // Every other stage is fed by its younger neighbour.
                assign up_valid   = valid_reg[gi-1];
                assign tag_in[gi] = tag_reg[gi-1];
            end

            assign kill   = flush & (IDX < flush_stage);
            assign hold   = stall_eff & (IDX <= stall_sel);
            assign bubble = stall_eff & (IDX == stall_sel + SW'(1));

            // Hold keeps the slot, kill/bubble empty it, otherwise advance.
            assign valid_next[gi] = hold ? valid_reg[gi]
                                  : (kill | bubble) ? 1'b0
                                  : up_valid;
            // Tags only move with valid data, so empty slots do not toggle.
            assign tag_load[gi]   = ~hold & ~kill & ~bubble & up_valid;

            assign stage_tag[gi*TAG_W +: TAG_W] = tag_reg[gi];
        end
    endgenerate

    // Refill gap: reload on a real flush, otherwise count down to zero.
    always_comb begin
        gap_next = gap_reg;
        if (flush && (flush_stage != '0)) begin
            gap_next = 3'(REFILL_GAP);
        end else if (gap_reg != 3'd0) begin
            gap_next = gap_reg - 3'd1;
        end
    end

    // Slot state and refill gap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            gap_reg   <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            gap_reg   <= gap_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (tag_load[i]) begin
                    tag_reg[i] <= tag_in[i];
                end
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] retired_reg;
    logic [31:0] bubbles_reg;
    logic        bubble_ins;

    // A bubble only counts when it actually separates a valid instruction.
    assign bubble_ins = stall_eff & (stall_sel != LAST) & valid_reg[stall_sel];

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= 32'd0;
            bubbles_reg <= 32'd0;
        end else begin
            if (retire_valid) begin
                retired_reg <= retired_reg + 32'd1;
            end
            if (bubble_ins) begin
                bubbles_reg <= bubbles_reg + 32'd1;
            end
        end
    end

    assign perf_retired = retired_reg;
    assign perf_bubbles = bubbles_reg;
`else
    assign perf_retired = 32'd0;
    assign perf_bubbles = 32'd0;
`endif

endmodule
